// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Defaults give a 12-bit subtract resolved 2 bits per cycle (6 digits).
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 12;
    localparam int DEF_DIGIT_W = 2;

    function automatic int num_digits(input int width, input int digit_w);
        return width / digit_w;
    endfunction

    localparam int DEF_N     = num_digits(DEF_WIDTH, DEF_DIGIT_W);
    localparam int DEF_CNT_W = $clog2(DEF_N);

endpackage

// File: rtl/sub_digit_cell.sv
// Combinational DIGIT_W-bit ripple subtractor: d_d = a_d - b_d - bin, bout = borrow out of the digit.
// Zero latency; no handshake, the caller decides when to register the result.
module sub_digit_cell
    import serial_sub_pkg::*;
#(
    parameter int DIGIT_W = DEF_DIGIT_W
) (
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d_d,
    output logic               bout
);

    logic [DIGIT_W:0] w_chain;

    always_comb begin
        w_chain    = '0;
        d_d        = '0;
        w_chain[0] = bin;
        for (int i = 0; i < DIGIT_W; i++) begin
            d_d[i]       = a_d[i] ^ b_d[i] ^ w_chain[i];
            // borrow when a < b + borrow at this bit position
            w_chain[i+1] = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & w_chain[i]);
        end
        bout = w_chain[DIGIT_W];
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned a - b, LSB digit first; out_valid rises N edges after accept, no overlapped accept.
// Result held stable in DONE until out_ready; optional ovf_signed port under SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIGIT_W = DEF_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf_signed
`endif
);

    localparam int N     = num_digits(WIDTH, DIGIT_W);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_borrow;
    logic [DIGIT_W-1:0] w_d;
    logic               w_bout;
    logic               w_accept;
    logic               w_run;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_run    = (r_state == RUN);

    sub_digit_cell #(
        .DIGIT_W (DIGIT_W)
    ) u_cell (
        .a_d  (r_a[DIGIT_W-1:0]),
        .b_d  (r_b[DIGIT_W-1:0]),
        .bin  (r_borrow),
        .d_d  (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (r_cnt == LAST) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands shift right so the active digit always sits in the low bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a      <= operand_a;
            r_b      <= operand_b;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (w_run) begin
            r_a      <= r_a >> DIGIT_W;
            r_b      <= r_b >> DIGIT_W;
            r_diff[int'(r_cnt)*DIGIT_W +: DIGIT_W] <= w_d;
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_ovf;

    // On the final digit the low bits of r_a/r_b hold the operand sign bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_run && (r_cnt == LAST)) begin
            r_ovf <= (r_a[DIGIT_W-1] ^ r_b[DIGIT_W-1]) & (w_d[DIGIT_W-1] ^ r_a[DIGIT_W-1]);
        end
    end

    assign ovf_signed = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed literal cases plus 1000 random operations
// checked every cycle against a queue-based model of the handshake and arithmetic.
module tb_serial_subtractor;

    localparam int W  = 12;
    localparam int DW = 2;
    localparam int N  = W / DW;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf_signed;
`endif

    serial_subtractor #(.WIDTH(W), .DIGIT_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .ovf_signed (ovf_signed)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    bit   busy    = 0;
    int   acc_cyc = 0;
    int   cyc     = 0;
    int   n_done  = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.d = a - b;
        e.b = (a < b);
        e.o = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        return e;
    endfunction

    // Inputs change just after posedge, so at negedge they show what the next edge will see.
    always @(negedge clk) begin
        if (rst) begin
            busy = 0;
            exp_q.delete();
        end else begin
            bit ov_exp;
            ov_exp = busy && ((cyc - acc_cyc) > N);
            chk("mon_in_ready", in_ready, !busy);
            chk("mon_out_valid", out_valid, ov_exp);
            if (ov_exp) begin
                chk("mon_diff", diff, exp_q[0].d);
                chk("mon_borrow", borrow_out, exp_q[0].b);
`ifdef SERIAL_SUB_OVERFLOW_EN
                chk("mon_ovf", ovf_signed, exp_q[0].o);
`endif
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    busy = 0;
                    n_done++;
                end
            end else if (!busy && in_valid) begin
                exp_q.push_back(model(operand_a, operand_b));
                busy    = 1;
                acc_cyc = cyc;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int lat;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, lat, N);
    endtask

    task automatic run_lit(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] d, input logic bo, input logic ov);
        send(a, b);
        wait_valid(nm);
        chk({nm, "_diff"}, diff, d);
        chk({nm, "_borrow"}, borrow_out, bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk({nm, "_ovf"}, ovf_signed, ov);
`else
        if (ov === 1'bx) chk({nm, "_ovf_arg"}, ov, 0);
`endif
        tick();
        chk({nm, "_ready_after"}, in_ready, 1);
        chk({nm, "_valid_after"}, out_valid, 0);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 9))
            0:       v = '0;
            1:       v = '1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int base;
        int acc;
        int guard;
        bit will;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operand_a = '0;
        operand_b = '0;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("rst_ovf", ovf_signed, 0);
`endif
        rst = 1'b0;
        tick();

        run_lit("basic", 12'h005, 12'h003, 12'h002, 1'b0, 1'b0);
        run_lit("borrow", 12'h000, 12'h001, 12'hFFF, 1'b1, 1'b0);
        run_lit("zero_minus_ones", 12'h000, 12'hFFF, 12'h001, 1'b1, 1'b0);
        run_lit("signed_ovf", 12'h800, 12'h001, 12'h7FF, 1'b0, 1'b1);

        // Backpressure with a competing request held high throughout RUN and DONE.
        out_ready = 1'b0;
        send(12'hABC, 12'h123);
        in_valid  = 1'b1;
        operand_a = 12'hFFF;
        operand_b = 12'h000;
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_diff", diff, 12'h999);
            chk("bp_borrow", borrow_out, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_ready_after", in_ready, 1);
        chk("bp_valid_after", out_valid, 0);

        // Reset in the middle of RUN discards the operation.
        send(12'h3C5, 12'h0A1);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_diff", diff, 0);
        chk("midrst_borrow", borrow_out, 0);
        tick();
        rst = 1'b0;
        tick();
        run_lit("a_eq_b", 12'h010, 12'h010, 12'h000, 1'b0, 1'b0);

        // Random back-to-back traffic with consumer stalls.
        base  = n_done;
        acc   = 0;
        guard = 0;
        while (acc < 1000 && guard < 60000) begin
            in_valid  = 1'b1;
            operand_a = pick();
            operand_b = ($urandom_range(0, 7) == 0) ? operand_a : pick();
            out_ready = ($urandom_range(0, 3) != 0);
            will      = in_ready;
            tick();
            if (will) acc++;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while ((n_done - base) < acc && guard < 200) begin
            tick();
            guard++;
        end
        chk("rand_accepted", acc, 1000);
        chk("rand_results", n_done - base, 1000);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
